// File: rtl/envelope_follower_pkg.sv
// Shared types and constants for the envelope follower and its slew stage.
// The step expansion matches the ADSR generator so both blocks move at the same rate.
package envelope_follower_pkg;
    localparam int ENV_W    = 16;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    function automatic logic [ENV_W-1:0] step_of(input logic [7:0] x);
        return {x, 8'd0};
    endfunction
endpackage

// File: rtl/envelope_slew.sv
// Rectifies a sample and moves the envelope towards it by one clamped attack/release step.
module envelope_slew
    import envelope_follower_pkg::*;
(
    input  logic [ENV_W-1:0]           env_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic [7:0]                 attack_i,
    input  logic [7:0]                 released_i,
    output logic [ENV_W-1:0]           env_o
);
    logic [SAMPLE_W-1:0] s_u;
    logic [SAMPLE_W-1:0] mag;
    logic [ENV_W-1:0]    rect;
    logic [ENV_W-1:0]    up_step;
    logic [ENV_W-1:0]    dn_step;
    logic [ENV_W:0]      diff_up;
    logic [ENV_W:0]      diff_dn;

    always_comb begin
        s_u     = sample_i;
        mag     = s_u[SAMPLE_W-1] ? (~s_u + 16'd1) : s_u;
        // Only -32768 leaves bit 15 set after negation; saturate it to full scale.
        rect    = mag[SAMPLE_W-1] ? 16'hFFFE : {mag[SAMPLE_W-2:0], 1'b0};
        up_step = step_of(attack_i);
        dn_step = step_of(released_i);
        diff_up = {1'b0, rect} - {1'b0, env_i};
        diff_dn = {1'b0, env_i} - {1'b0, rect};
        env_o   = env_i;
        if (rect > env_i) begin
            if (attack_i == 8'd0 || diff_up <= {1'b0, up_step}) env_o = rect;
            else                                               env_o = env_i + up_step;
        end else if (rect < env_i) begin
            if (released_i == 8'd0 || diff_dn <= {1'b0, dn_step}) env_o = rect;
            else                                                 env_o = env_i - dn_step;
        end
    end
endmodule

// File: rtl/envelope_follower.sv
// Envelope follower: slews a rectified sample stream and runs a hysteretic, hold-extended
// note gate that emits note_on/note_off pulses and tracks the per-note peak level.
module envelope_follower
    import envelope_follower_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic [7:0]                 attack,
    input  logic [7:0]                 released,
    input  logic [7:0]                 on_threshold,
    input  logic [7:0]                 off_threshold,
    input  logic [7:0]                 hold,
    output logic [ENV_W-1:0]           envelope_out,
    output logic                       gate,
    output logic                       note_on,
    output logic                       note_off,
    output logic [ENV_W-1:0]           peak_out
);
    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [ENV_W-1:0] env_q, env_d, peak_q, peak_d, env_nxt;
    logic             gate_q, gate_d, on_q, on_d, off_q, off_d;
    logic [7:0]       lvl;

    envelope_slew u_slew (
        .env_i      (env_q),
        .sample_i   (sample),
        .attack_i   (attack),
        .released_i (released),
        .env_o      (env_nxt)
    );

    assign lvl = env_nxt[ENV_W-1:8];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        env_d   = env_q;
        peak_d  = peak_q;
        on_d    = 1'b0;
        off_d   = 1'b0;
        if (sample_valid) env_d = env_nxt;
        case (state_q)
            ST_IDLE: begin
                if (sample_valid && lvl >= on_threshold) begin
                    state_d = ST_ACTIVE;
                    on_d    = 1'b1;
                    peak_d  = env_nxt;
                end
            end
            ST_ACTIVE: begin
                if (sample_valid) begin
                    if (env_nxt > peak_q) peak_d = env_nxt;
                    if (lvl < off_threshold) begin
                        if (hold == 8'd0) begin
                            state_d = ST_IDLE;
                            off_d   = 1'b1;
                        end else begin
                            state_d = ST_HOLD;
                            cnt_d   = hold;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (sample_valid) begin
                    if (env_nxt > peak_q) peak_d = env_nxt;
                    if (lvl >= off_threshold) begin
                        state_d = ST_ACTIVE;
                    end else if (cnt_q <= 8'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                        off_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        gate_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            env_q   <= '0;
            peak_q  <= '0;
            gate_q  <= 1'b0;
            on_q    <= 1'b0;
            off_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            env_q   <= env_d;
            peak_q  <= peak_d;
            gate_q  <= gate_d;
            on_q    <= on_d;
            off_q   <= off_d;
        end
    end

    assign envelope_out = env_q;
    assign gate         = gate_q;
    assign note_on      = on_q;
    assign note_off     = off_q;
    assign peak_out     = peak_q;
endmodule

// File: tb/tb_envelope_follower.sv
// Scoreboard bench: the driver pushes model predictions per clock, a monitor pops and compares.
module tb_envelope_follower;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sample_valid = 1'b0;
    logic signed [15:0] sample = '0;
    logic [7:0] attack = '0, released = '0, on_threshold = '0, off_threshold = '0, hold = '0;
    logic [15:0] envelope_out, peak_out;
    logic gate, note_on, note_off;

    envelope_follower dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .attack(attack), .released(released), .on_threshold(on_threshold),
        .off_threshold(off_threshold), .hold(hold), .envelope_out(envelope_out),
        .gate(gate), .note_on(note_on), .note_off(note_off), .peak_out(peak_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] env;
        logic        gate, on, off;
        logic [15:0] peak;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   n_total = 0, n_pass = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Behavioural model state
    int m_env = 0, m_peak = 0, m_grace = 0;
    bit m_sound = 0, m_on = 0, m_off = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic void model_reset();
        m_env = 0; m_peak = 0; m_grace = 0; m_sound = 0; m_on = 0; m_off = 0;
    endfunction

    function automatic void model_sample(input int s);
        int rect, step, lvl;
        rect = (s == -32768) ? 65534 : ((s < 0) ? -s : s) * 2;
        if (rect > m_env) begin
            step = attack * 256;
            m_env = (attack == 0 || rect - m_env <= step) ? rect : m_env + step;
        end else if (rect < m_env) begin
            step = released * 256;
            m_env = (released == 0 || m_env - rect <= step) ? rect : m_env - step;
        end
        lvl = m_env / 256;
        m_on = 0; m_off = 0;
        if (!m_sound) begin
            if (lvl >= on_threshold) begin
                m_sound = 1; m_on = 1; m_peak = m_env; m_grace = 0;
            end
        end else begin
            if (m_env > m_peak) m_peak = m_env;
            if (lvl >= off_threshold) m_grace = 0;          // back to fully sounding
            else if (m_grace == 0) begin                    // first quiet sample
                if (hold == 0) begin m_sound = 0; m_off = 1; end
                else m_grace = hold;
            end else if (m_grace == 1) begin
                m_sound = 0; m_off = 1; m_grace = 0;
            end else m_grace--;
        end
    endfunction

    // Called at posedge+1; returns at the posedge+1 after the sample was clocked in.
    task automatic drive(input bit v, input logic [15:0] s);
        exp_t e;
        sample_valid = v;
        sample = s;
        if (v) model_sample($signed(s));
        else begin m_on = 0; m_off = 0; end
        e.cyc = edge_cnt + 1; e.env = m_env[15:0]; e.gate = m_sound;
        e.on = m_on; e.off = m_off; e.peak = m_peak[15:0];
        q.push_back(e);
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic set_cfg(input logic [7:0] a, r, on_t, off_t, h);
        attack = a; released = r; on_threshold = on_t; off_threshold = off_t; hold = h;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
                e = q.pop_front();
                chk("envelope_out", envelope_out, e.env);
                chk("gate", gate, e.gate);
                chk("note_on", note_on, e.on);
                chk("note_off", note_off, e.off);
                chk("peak_out", peak_out, e.peak);
                if (note_on && note_off) chk("pulse_exclusive", 1, 0);
            end
        end
    end

    initial begin : stim
        int budget;
        #3;
        chk("rst_env", envelope_out, 0); chk("rst_gate", gate, 0);
        chk("rst_on", note_on, 0); chk("rst_off", note_off, 0); chk("rst_peak", peak_out, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        // Attack ramp to 0x8000, gate opens at 0x4000
        set_cfg(8'h10, 8'h00, 8'h40, 8'h20, 8'd0);
        for (int i = 0; i < 9; i++) drive(1'b1, 16'sd16384);
        chk("ramp_env", envelope_out, 16'h8000);
        chk("ramp_peak", peak_out, 16'h8000);

        // Full-scale negative saturates
        set_cfg(8'h00, 8'h00, 8'h40, 8'h20, 8'd0);
        drive(1'b1, 16'h8000);
        chk("fs_env", envelope_out, 16'hFFFE);
        chk("fs_peak", peak_out, 16'hFFFE);

        // Release clamp from 0x0300
        drive(1'b1, 16'sd384);
        released = 8'h02;
        drive(1'b1, 16'sd0);
        drive(1'b1, 16'sd0);
        chk("rel_env", envelope_out, 0);

        // Hold and re-trigger
        set_cfg(8'h00, 8'h00, 8'h40, 8'h20, 8'd3);
        drive(1'b1, 16'sd16384);
        drive(1'b1, 16'sd0); drive(1'b1, 16'sd0);
        drive(1'b1, 16'sd16384);
        for (int i = 0; i < 3; i++) drive(1'b1, 16'sd0);
        chk("hold_gate", gate, 1);
        drive(1'b1, 16'sd0);
        chk("hold_off", note_off, 1);

        // Idle strobes while active
        drive(1'b1, 16'sd20000);
        for (int i = 0; i < 100; i++) drive(1'b0, 16'(i * 97));

        // Mid-note reset between edges
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        chk("mrst_env", envelope_out, 0); chk("mrst_gate", gate, 0);
        chk("mrst_on", note_on, 0); chk("mrst_off", note_off, 0); chk("mrst_peak", peak_out, 0);
        q.delete();
        model_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 16'sd0);
        chk("post_rst_gate", gate, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] s;
            if ($urandom_range(0, 15) == 0)
                set_cfg(8'($urandom_range(0, 64)), 8'($urandom_range(0, 64)),
                        8'($urandom_range(32, 160)), 8'($urandom_range(8, 40)),
                        8'($urandom_range(0, 4)));
            case ($urandom_range(0, 5))
                0:       s = 16'h8000;
                1, 2:    s = 16'($urandom_range(0, 300));
                default: s = 16'($urandom);
            endcase
            drive($urandom_range(0, 4) != 0, s);
        end

        budget = 0;
        while (q.size() > 0 && budget < 20) begin @(posedge clk); budget++; end
        if (q.size() > 0) chk("scoreboard_drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/envelope_follower.md
# envelope_follower

Analysis-side counterpart of the ADSR envelope generator: consumes a stream of signed audio samples and recovers an amplitude envelope. Its attack/release step semantics match the generator's. It applies a hysteretic, hold-extended gate to the envelope to decide when a note is sounding. It emits note-on/note-off pulses and a per-note peak level for the emotion-analysis front end.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- sample_valid  in  1  one-cycle strobe marking a new sample; may be high on consecutive cycles.
- sample  in  16  signed two's-complement audio sample; qualified by sample_valid.
- attack  in  8  rise step, applied as {attack, 8'd0} per sample; 0 means immediate.
- released  in  8  fall step, applied as {released, 8'd0} per sample; 0 means immediate.
- on_threshold  in  8  gate-on level, compared against envelope[15:8].
- off_threshold  in  8  gate-off level, compared against envelope[15:8].
- hold  in  8  extra below-threshold samples tolerated before the gate drops.
- envelope_out  out  16  current unsigned envelope, 0..0xFFFE.
- gate  out  1  high while a note is considered sounding.
- note_on  out  1  one-cycle pulse when the gate rises.
- note_off  out  1  one-cycle pulse when the gate falls.
- peak_out  out  16  maximum envelope since the last note_on; retained after note_off.

## Operation
- **Rectify.** rect = |sample| << 1.
  - -32768 saturates to 32767 before the shift, so rect = 0xFFFE.
  - rect is 16-bit unsigned, so its range is 0..0xFFFE.
- **Slew.** Applies only on sample_valid; otherwise the envelope holds. Let E be the current envelope and E' the next envelope.
  - rect > E: if attack == 0 or rect − E ≤ step, E' = rect; otherwise E' = E + step.
  - rect < E: if released == 0 or E − rect ≤ step, E' = rect; otherwise E' = E − step.
  - rect == E: E' = E.
  - Clamping to rect means the envelope never overshoots, wraps, or underflows. Compute in 17 bits where needed.
- **Gate FSM.** States IDLE, ACTIVE, HOLD. Transitions are evaluated only on sample_valid, using E'[15:8] (the new envelope, not the old one).
  - IDLE: E'[15:8] ≥ on_threshold → ACTIVE; assert note_on; load peak with E'.
  - ACTIVE, E'[15:8] ≥ off_threshold: stay in ACTIVE; peak = max(peak, E').
  - ACTIVE, E'[15:8] < off_threshold, hold == 0: → IDLE; assert note_off.
  - ACTIVE, E'[15:8] < off_threshold, hold ≠ 0: → HOLD; load cnt = hold.
  - HOLD, E'[15:8] ≥ off_threshold: → ACTIVE; no note_on; update peak.
  - HOLD, E'[15:8] < off_threshold, cnt == 1: → IDLE; assert note_off.
  - HOLD, E'[15:8] < off_threshold, cnt > 1: cnt − 1.
  - Net effect: the gate falls on the (hold+1)-th consecutive below-off sample.
  - gate = (state != IDLE), registered.
- **Peak.** peak_out is updated in ACTIVE and HOLD on every sample_valid and is frozen in IDLE.
- **Unused encoding.** Any unused FSM encoding → IDLE, with cnt = 0.
- **Thresholds.** Threshold, hold and step inputs are sampled at each sample_valid. Changes take effect from the next sample; in-flight cnt is not reloaded.

## Timing
- Reset values: envelope_out 0, gate 0, note_on 0, note_off 0, peak_out 0, state IDLE, cnt 0. Reset is effective asynchronously, mid-note included; no note_off is emitted.
- Latency: a sample presented with sample_valid at edge N is reflected in envelope_out, gate, peak_out and the note_on/note_off pulses after edge N. Everything is one cycle and all outputs are registered.
- note_on and note_off are never high in the same cycle. Each lasts exactly one clk cycle, even with back-to-back sample_valid.
- Cycles without sample_valid leave every output unchanged, except that the pulses return to 0.

## Structure
- Shared package holds:
  - state encodings ST_IDLE = 0, ST_ACTIVE = 1, ST_HOLD = 2;
  - ENV_W = 16 and SAMPLE_W = 16;
  - the step-expansion convention {x, 8'd0}, shared with the ADSR block.
- One sub-module is natural: envelope_slew. It takes E, rect, attack and released, and produces E' combinationally as rectify plus clamped step. The top level holds the FSM, cnt, peak and the registers.

## Test plan
- Reset mid-note: drive gate high, then assert reset = 0 between edges → all outputs read 0 before the next edge; after release, a 0x0000 sample keeps gate = 0.
- Attack ramp: attack = 0x10, on_threshold = 0x40, sample = +16384 (rect 0x8000) every cycle.
  - envelope_out reads 0x1000, 0x2000, … and saturates at 0x8000 on the 8th sample.
  - gate and note_on rise on the 4th sample (E' = 0x4000).
  - peak_out reads 0x8000.
- Full-scale negative: attack = 0, sample = −32768 → envelope_out = 0xFFFE after one sample, gate = 1, peak_out = 0xFFFE.
- Release clamp: E = 0x0300, released = 0x02, rect 0 → envelope_out reads 0x0100, then 0x0000; no wrap.
- Hold and re-trigger: off_threshold = 0x20, hold = 3, released = 0.
  - Two zero samples, then one 0x4000 sample → gate stays 1 throughout; no pulses.
  - Then four zero samples → gate falls and note_off pulses on the 4th.
- Idle strobes: sample_valid = 0 for 100 cycles during ACTIVE → all outputs unchanged; pulses stay 0.
